// File: rtl/jk_excitation_driver.sv
// Queues target patterns and drives a bank of JK flip-flops toward each one.
// Each target takes one DRIVE cycle and one CHECK cycle; a failed check pulses mismatch.
module jk_excitation_driver #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic             busy,
    output logic             mismatch,
    output logic [7:0]       err_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, DRIVE, CHECK} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      cnt_q;
    logic [WIDTH-1:0] t_q, t_d;
    logic [WIDTH-1:0] j_q, j_d, k_q, k_d;
    logic             mismatch_q, mismatch_d;
    logic [7:0]       err_q, err_d;
    logic             full, empty, push, pop;
    logic [WIDTH-1:0] head;

    // Flow control looks only at registered occupancy, so a pop never opens a slot early.
    assign full     = (cnt_q == CNT_FULL);
    assign empty    = (cnt_q == '0);
    assign in_ready = ~full;
    assign push     = in_valid & ~full;
    assign head     = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // j/k are loaded on the edge entering DRIVE, so the flops see them during
    // DRIVE and CHECK observes the settled result.
    always_comb begin
        state_d    = state_q;
        t_d        = t_q;
        j_d        = '0;
        k_d        = '0;
        pop        = 1'b0;
        mismatch_d = 1'b0;
        err_d      = err_q;
        unique case (state_q)
            IDLE: begin
                if (!empty) pop = 1'b1;
            end
            DRIVE: begin
                state_d = CHECK;
            end
            CHECK: begin
                if (q_fb != t_q) begin
                    mismatch_d = 1'b1;
                    if (err_q != 8'hFF) err_d = err_q + 8'd1;
                end
                if (!empty) pop = 1'b1;
                else        state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (pop) begin
            t_d     = head;
            j_d     = head & ~q_fb;
            k_d     = ~head & q_fb;
            state_d = DRIVE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            t_q        <= '0;
            j_q        <= '0;
            k_q        <= '0;
            mismatch_q <= 1'b0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            t_q        <= t_d;
            j_q        <= j_d;
            k_q        <= k_d;
            mismatch_q <= mismatch_d;
            err_q      <= err_d;
        end
    end

    assign j         = j_q;
    assign k         = k_q;
    assign mismatch  = mismatch_q;
    assign err_count = err_q;
    assign busy      = (state_q != IDLE) || !empty;

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Drives jk_excitation_driver against a queue-based reference and an ideal JK plant.
module tb_jk_excitation_driver;
    localparam int W = 4;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_data = '0;
    logic [W-1:0] q_fb = '0;
    logic         in_ready, busy, mismatch;
    logic [W-1:0] j, k;
    logic [7:0]   err_count;

    int checks = 0;
    int errors = 0;

    // Reference: pending targets, phase (0 idle, 1 drive, 2 check), expected outputs
    logic [W-1:0] m_q[$];
    int           m_ph;
    logic [W-1:0] m_t, m_j, m_k;
    bit           m_mis;
    int           m_err;
    bit           stuck;
    int           pulses;
    bit           saw_full;
    string        tag;

    jk_excitation_driver #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .q_fb(q_fb), .j(j), .k(k), .busy(busy),
        .mismatch(mismatch), .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ph = 0; m_t = '0; m_j = '0; m_k = '0; m_mis = 1'b0; m_err = 0;
    endtask

    task automatic check_outputs();
        chk({tag, ".j"}, j, m_j);
        chk({tag, ".k"}, k, m_k);
        chk({tag, ".in_ready"}, in_ready, m_q.size() < D);
        chk({tag, ".busy"}, busy, (m_ph != 0) || (m_q.size() > 0));
        chk({tag, ".mismatch"}, mismatch, m_mis);
        chk({tag, ".err_count"}, err_count, m_err);
    endtask

    // One clock: predict from pre-edge values, clock, update plant, compare.
    task automatic step(input bit v, input logic [W-1:0] d, output bit acc);
        logic [W-1:0] pj, pk, qs;
        bit pop;
        in_valid = v;
        in_data  = d;
        qs  = q_fb;
        pj  = j;
        pk  = k;
        acc = v && (m_q.size() < D);
        if (m_q.size() == D) saw_full = 1'b1;
        pop   = (m_ph != 1) && (m_q.size() > 0);
        m_mis = (m_ph == 2) && (qs != m_t);
        if (m_mis && m_err < 255) m_err++;
        if (pop) begin
            m_t  = m_q.pop_front();
            m_j  = m_t & ~qs;
            m_k  = ~m_t & qs;
            m_ph = 1;
        end else begin
            m_j  = '0;
            m_k  = '0;
            m_ph = (m_ph == 1) ? 2 : 0;
        end
        if (acc) m_q.push_back(d);
        @(posedge clk);
        #1;
        q_fb = stuck ? '0 : ((pj & ~qs) | (~pk & qs));
        if (mismatch) pulses++;
        check_outputs();
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        model_reset();
        tag = "reset";
        check_outputs();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        bit acc;
        int n, guard;
        logic [W-1:0] tgt;

        // Reset values
        stuck = 1'b0; q_fb = '0; pulses = 0; saw_full = 1'b0;
        do_reset();

        // Single target from all-zero state
        tag = "t031";
        step(1'b1, 4'b1010, acc);
        step(1'b0, '0, acc);
        chk("t031.drive_j", j, 4'b1010);
        chk("t031.drive_k", k, 4'b0000);
        step(1'b0, '0, acc);
        step(1'b0, '0, acc);
        chk("t031.q_fb", q_fb, 4'b1010);
        chk("t031.pulses", pulses, 0);

        // Set and reset in the same drive; held bits get 00
        tag = "t032";
        q_fb = 4'b1100;
        step(1'b1, 4'b0110, acc);
        step(1'b0, '0, acc);
        chk("t032.drive_j", j, 4'b0010);
        chk("t032.drive_k", k, 4'b1000);
        step(1'b0, '0, acc);
        step(1'b0, '0, acc);
        chk("t032.q_fb", q_fb, 4'b0110);
        chk("t032.pulses", pulses, 0);

        // Back-to-back burst outruns the 2-cycle drain and fills the FIFO
        tag = "t033";
        n = 0; guard = 0;
        while (n < 8 && guard < 100) begin
            tgt = W'(n * 5 + 3);
            step(1'b1, tgt, acc);
            if (acc) n++;
            guard++;
        end
        chk("t033.accepted", n, 8);
        chk("t033.full_seen", saw_full, 1'b1);
        guard = 0;
        while ((m_ph != 0 || m_q.size() > 0) && guard < 100) begin
            step(1'b0, '0, acc);
            guard++;
        end
        chk("t033.drained", busy, 1'b0);
        chk("t033.pulses", pulses, 0);

        // Reset in DRIVE with three targets queued
        tag = "t035";
        guard = 0;
        while (!(m_ph == 1 && m_q.size() >= 3) && guard < 40) begin
            step(1'b1, W'($urandom), acc);
            guard++;
        end
        chk("t035.setup", (m_ph == 1) && (m_q.size() >= 3), 1'b1);
        in_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        tag = "t035.inreset";
        check_outputs();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        tag = "t035.after";
        for (int i = 0; i < 6; i++) step(1'b0, '0, acc);
        chk("t035.busy", busy, 1'b0);

        // Feedback stuck at zero: every check fails, counter saturates
        tag = "t034";
        do_reset();
        stuck = 1'b1; q_fb = '0; pulses = 0;
        n = 0; guard = 0;
        while ((n < 300 || m_ph != 0 || m_q.size() > 0) && guard < 2000) begin
            step(n < 300, 4'b0001, acc);
            if (acc) n++;
            guard++;
        end
        chk("t034.accepted", n, 300);
        chk("t034.pulses", pulses, 300);
        chk("t034.err_sat", err_count, 8'd255);

        // Random traffic with occasional stuck feedback
        tag = "rand";
        do_reset();
        stuck = 1'b0; q_fb = W'($urandom);
        for (int i = 0; i < 400; i++) begin
            if (i % 25 == 0) stuck = ($urandom_range(0, 3) == 0);
            step($urandom_range(0, 2) != 0, W'($urandom), acc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
